// File: rtl/pcie_irq_pkg.sv
// Shared types and widths for the PCIe MSI interrupt scheduler and its arbiter.
package pcie_irq_pkg;
   localparam int VEC_W = 5;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
endpackage

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin pick: first set request bit after last_grant, wrapping at IRQ_COUNT-1.
module pcie_rr_arbiter
   import pcie_irq_pkg::*;
#(
   parameter int IRQ_COUNT = 32
) (
   input  logic [IRQ_COUNT-1:0] req,
   input  logic [VEC_W-1:0]     last_grant,
   output logic [VEC_W-1:0]     winner,
   output logic                 valid
);

   int idx;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int i = IRQ_COUNT; i >= 1; i--) begin
         idx = int'(last_grant) + i;
         if (idx >= IRQ_COUNT) idx = idx - IRQ_COUNT;
         if (req[idx]) begin
            winner = VEC_W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcie_msi_scheduler.sv
// Round-robin scheduler of up to 32 interrupt sources onto one PCIe request/ack interrupt port.
// Optional ack timeout with retry is built when PCIE_MSI_TIMEOUT_EN is defined.
module pcie_msi_scheduler
   import pcie_irq_pkg::*;
#(
   parameter int IRQ_COUNT   = 32,
   parameter int HOLDOFF     = 4,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IRQ_COUNT-1:0] IRQ_IN,
   input  logic [IRQ_COUNT-1:0] irq_mask,
   input  logic                 global_enable,
   input  logic                 msi_enable,
   output logic                 IRQ_REQ,
   output logic [VEC_W-1:0]     IRQ_VECTOR,
   input  logic                 IRQ_ACK,
   output logic [IRQ_COUNT-1:0] pending,
   output logic                 busy,
   output logic [CNT_W-1:0]     coalesce_count,
   output logic [CNT_W-1:0]     timeout_count
);

   localparam int TMR_MAX = (ACK_TIMEOUT > HOLDOFF) ? ACK_TIMEOUT : HOLDOFF;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   state_t                 state_q, state_d;
   logic                   req_q, req_d;
   logic [VEC_W-1:0]       vec_q, vec_d;
   logic [VEC_W-1:0]       last_q, last_d;
   logic [TMR_W-1:0]       cnt_q, cnt_d;
   logic [IRQ_COUNT-1:0]   pending_q, pending_d;
   logic [IRQ_COUNT-1:0]   mask_q;
   logic [CNT_W-1:0]       coal_q, coal_d;

   logic [VEC_W-1:0]       arb_winner;
   logic                   arb_valid;
   logic                   grant;
   logic [IRQ_COUNT-1:0]   grant_oh;
   logic [IRQ_COUNT-1:0]   retry_oh;
   logic [IRQ_COUNT-1:0]   hit;
   logic [6:0]             hit_cnt;
   logic [CNT_W:0]         coal_sum;

   // The mask is registered, so unmasking a pending source behaves like a fresh strobe (two cycles).
   pcie_rr_arbiter #(.IRQ_COUNT(IRQ_COUNT)) u_arb (
      .req        (pending_q & mask_q),
      .last_grant (last_q),
      .winner     (arb_winner),
      .valid      (arb_valid)
   );

`ifdef PCIE_MSI_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);
   logic                   tmo;
   logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      vec_d   = vec_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;
`ifdef PCIE_MSI_TIMEOUT_EN
      tmo     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (arb_valid && global_enable && msi_enable) begin
               grant   = 1'b1;
               vec_d   = arb_winner;
               last_d  = arb_winner;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (IRQ_ACK) begin
               req_d = 1'b0;
               if (HOLDOFF > 0) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LAST;
               end else begin
                  state_d = IDLE;
               end
            end
`ifdef PCIE_MSI_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               req_d = 1'b0;
               tmo   = 1'b1;
               if (HOLDOFF > 0) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LAST;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         HOLD: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < IRQ_COUNT; gi++) begin : g_src
      assign grant_oh[gi] = grant && (arb_winner == VEC_W'(gi));
`ifdef PCIE_MSI_TIMEOUT_EN
      assign retry_oh[gi] = tmo && (vec_q == VEC_W'(gi));
`else
      assign retry_oh[gi] = 1'b0;
`endif
   end

   // A strobe landing on the bit being granted re-arms it rather than coalescing.
   assign hit = IRQ_IN & pending_q & ~grant_oh;

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < IRQ_COUNT; i++) hit_cnt = hit_cnt + 7'(hit[i]);
      coal_sum  = {1'b0, coal_q} + (CNT_W + 1)'(hit_cnt);
      coal_d    = coal_sum[CNT_W] ? '1 : coal_sum[CNT_W-1:0];
      pending_d = (pending_q & ~grant_oh) | IRQ_IN | retry_oh;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         vec_q     <= '0;
         last_q    <= VEC_W'(IRQ_COUNT - 1);
         cnt_q     <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         coal_q    <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         vec_q     <= vec_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         mask_q    <= irq_mask;
         coal_q    <= coal_d;
      end
   end

`ifdef PCIE_MSI_TIMEOUT_EN
   assign tmo_cnt_d = (tmo && (tmo_cnt_q != '1)) ? tmo_cnt_q + 1'b1 : tmo_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tmo_cnt_q <= '0;
      else       tmo_cnt_q <= tmo_cnt_d;
   end

   assign timeout_count = tmo_cnt_q;
`else
   assign timeout_count = '0;
`endif

   assign IRQ_REQ        = req_q;
   assign IRQ_VECTOR     = vec_q;
   assign pending        = pending_q;
   assign busy           = (state_q != IDLE);
   assign coalesce_count = coal_q;

endmodule

// File: doc/pcie_msi_scheduler.md
# pcie_msi_scheduler

Sequences vectored (MSI-style) interrupt requests from up to 32 on-chip sources onto the PCIe bridge's single request/acknowledge interrupt port. Sources strobe IRQ_IN. The block latches each strobe as a pending bit, picks one eligible source round-robin, and drives IRQ_REQ/IRQ_VECTOR until the bridge acknowledges. It sits between the interrupt-producing datapath blocks and the bridge, and replaces per-design ad-hoc sharing of the bridge interrupt port.

## Interface
- IRQ_COUNT, default 32: number of sources, range 1..32.
- HOLDOFF, default 4: idle cycles forced between an acknowledge and the next request; 0 allowed.
- ACK_TIMEOUT, default 1024: cycles to wait for IRQ_ACK. Used only with PCIE_MSI_TIMEOUT_EN.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- IRQ_IN  in  IRQ_COUNT  per-source one-cycle strobes.
- irq_mask  in  IRQ_COUNT  1 = source eligible for arbitration.
- global_enable  in  1  0 = no new requests are started.
- msi_enable  in  1  bridge reports MSI enabled; ANDed with global_enable.
- IRQ_REQ  out  1  request to bridge; reset 0.
- IRQ_VECTOR  out  5  granted source number, valid while IRQ_REQ=1; reset 0.
- IRQ_ACK  in  1  bridge acknowledge, one-cycle pulse.
- pending  out  IRQ_COUNT  latched pending bits; reset 0.
- busy  out  1  state is not IDLE; reset 0.
- coalesce_count  out  16  saturating count of strobes that hit an already-pending bit; reset 0.
- timeout_count  out  16  saturating count of ack timeouts; reset 0.

## Operation
- Pending bit k is set on any edge where IRQ_IN[k]=1. This includes masked sources: they latch, but are not eligible until unmasked.
- Pending bit k is cleared on the edge that grants k. A strobe on k in that same cycle wins, so the bit stays 1.
- A strobe on an already-set bit is not lost as an event: it increments coalesce_count, saturating at 16'hFFFF.
- Eligible set = pending & irq_mask, considered only when global_enable & msi_enable = 1.
- Round-robin search starts at last_grant+1 and wraps at IRQ_COUNT-1 back to 0. last_grant resets to IRQ_COUNT-1, so source 0 has first priority after reset.
- States:
  - IDLE: if eligible set ≠ 0, latch the winner into IRQ_VECTOR and last_grant, set IRQ_REQ=1, go to REQ.
  - REQ: hold IRQ_REQ and IRQ_VECTOR stable. When IRQ_ACK=1, clear IRQ_REQ; go to HOLD if HOLDOFF>0, else IDLE.
  - HOLD: count HOLDOFF cycles, then go to IDLE.
- Dropping global_enable or msi_enable during REQ does not withdraw the request. The transaction runs to ACK; the block then stalls in IDLE.
- IRQ_ACK outside REQ is ignored.
- IRQ_COUNT<32: IRQ_VECTOR upper bits are 0, and unused vectors are never issued.

## Timing
- IRQ_IN[k] high in cycle N: pending[k]=1 from N+1; IRQ_REQ=1 from N+2 when IDLE and eligible.
- IRQ_ACK high in cycle M: IRQ_REQ=0 from M+1. The next IRQ_REQ is no earlier than M+2+HOLDOFF.
- Back-to-back throughput: one request per (ack latency + HOLDOFF + 2) cycles.
- Reset asserted mid-transaction: IRQ_REQ, pending, busy and the counters clear immediately, without waiting for clk. The bridge request is abandoned.

## Configuration
- PCIE_MSI_TIMEOUT_EN defined: a counter runs in REQ. After ACK_TIMEOUT cycles without IRQ_ACK, the block:
  - drops IRQ_REQ
  - re-sets the pending bit of IRQ_VECTOR
  - increments timeout_count
  - enters HOLD, so the source is retried at a later arbitration.
- PCIE_MSI_TIMEOUT_EN undefined: REQ waits for IRQ_ACK indefinitely, and timeout_count is tied to 0.

## Structure
- Shared package pcie_irq_pkg holds:
  - the state enum (IDLE, REQ, HOLD)
  - the vector width constant (5)
  - the counter width constant (16).
- Sub-module pcie_rr_arbiter: combinational round-robin pick of request vector and last grant, producing winner index and valid.

## Test plan
- Single strobe on IRQ_IN[3], enables=1, ACK 5 cycles after REQ: IRQ_REQ high 2 cycles after strobe, IRQ_VECTOR=3, pending[3]=0 after grant, then idle.
- Strobes on sources 0, 1 and 31 in the same cycle: vectors issue in order 0, 1, 31, each with HOLDOFF=4 gaps between ACK and next REQ.
- Source 2 strobed three times while pending: coalesce_count=2 and only one request issued. A strobe on source 2 in its grant cycle yields a second request.
- irq_mask[5]=0 with source 5 strobed: pending[5]=1, no request. Setting irq_mask[5]=1 gives IRQ_REQ with vector 5 two cycles later.
- global_enable dropped during REQ: ACK still completes the transaction, no new request follows while disabled. Async reset asserted during REQ clears IRQ_REQ immediately.
- With PCIE_MSI_TIMEOUT_EN and ACK_TIMEOUT=16, no ACK: IRQ_REQ drops after 16 cycles, timeout_count=1, vector retried after HOLD.
